// File: rtl/softmax_reciprocal_if.sv
// softmax_reciprocal_if: sum-in / reciprocal-out handshake bundle for softmax_reciprocal.
interface softmax_reciprocal_if #(
   parameter int SUM_WIDTH = 24,
   parameter int BIT_WIDTH = 16
);
   logic                 i_valid;
   logic [SUM_WIDTH-1:0] i_sum;
   logic                 o_ready;
   logic                 o_valid;
   logic [BIT_WIDTH-1:0] o_recip;
   logic                 o_sat;
   logic                 o_div_zero;
   logic                 i_ready;
   modport master (output i_valid, i_sum, i_ready, input o_ready, o_valid, o_recip, o_sat, o_div_zero);
   modport slave  (input i_valid, i_sum, i_ready, output o_ready, o_valid, o_recip, o_sat, o_div_zero);
endinterface

// File: rtl/softmax_reciprocal.sv
// softmax_reciprocal: rounded Q0.16 reciprocal of a Q.12 exponential sum via 30-step restoring division.
module softmax_reciprocal #(
   parameter int SUM_WIDTH = 24,
   parameter int BIT_WIDTH = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   softmax_reciprocal_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t               state, state_nx;
   logic [4:0]           cnt, cnt_nx;
   logic [SUM_WIDTH:0]   rem, rem_nx, rem_sh;
   logic [SUM_WIDTH-1:0] div, div_nx;
   logic [BIT_WIDTH:0]   quo, quo_nx, quo_sh, rnd;
   logic                 ge;
   logic                 ready, ready_nx, valid, valid_nx, sat, sat_nx, dz, dz_nx;
   logic [BIT_WIDTH-1:0] recip, recip_nx;
   // dividend is 2^29, so only the first shifted-in bit is a one
   assign rem_sh = (rem << 1) | (SUM_WIDTH+1)'(cnt == 5'd0);
   assign ge     = rem_sh >= {1'b0, div};
   assign quo_sh = (quo << 1) | (BIT_WIDTH+1)'(ge);
   assign rnd    = (BIT_WIDTH+1)'(({1'b0, quo_sh} + (BIT_WIDTH+2)'(1)) >> 1);
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         rem   <= '0;
         div   <= '0;
         quo   <= '0;
         ready <= 1'b1;
         valid <= 1'b0;
         recip <= '0;
         sat   <= 1'b0;
         dz    <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         rem   <= rem_nx;
         div   <= div_nx;
         quo   <= quo_nx;
         ready <= ready_nx;
         valid <= valid_nx;
         recip <= recip_nx;
         sat   <= sat_nx;
         dz    <= dz_nx;
      end
   end
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      rem_nx   = rem;
      div_nx   = div;
      quo_nx   = quo;
      ready_nx = ready;
      valid_nx = valid;
      recip_nx = recip;
      sat_nx   = sat;
      dz_nx    = dz;
      case (state)
         IDLE: if (bus.i_valid) begin
            div_nx   = bus.i_sum;
            cnt_nx   = '0;
            rem_nx   = '0;
            quo_nx   = '0;
            ready_nx = 1'b0;
            // sums up to 1.0 saturate without dividing
            if (bus.i_sum <= SUM_WIDTH'(4096)) begin
               state_nx = DONE;
               valid_nx = 1'b1;
               recip_nx = '1;
               sat_nx   = 1'b1;
               dz_nx    = bus.i_sum == '0;
            end else begin
               state_nx = CALC;
            end
         end
         CALC: begin
            cnt_nx = cnt + 5'd1;
            rem_nx = ge ? rem_sh - {1'b0, div} : rem_sh;
            quo_nx = quo_sh;
            if (cnt == 5'd29) begin
               state_nx = DONE;
               valid_nx = 1'b1;
               sat_nx   = rnd[BIT_WIDTH];
               recip_nx = rnd[BIT_WIDTH] ? '1 : rnd[BIT_WIDTH-1:0];
               dz_nx    = 1'b0;
            end
         end
         DONE: if (bus.i_ready) begin
            state_nx = IDLE;
            ready_nx = 1'b1;
            valid_nx = 1'b0;
            recip_nx = '0;
            sat_nx   = 1'b0;
            dz_nx    = 1'b0;
         end
         default: state_nx = IDLE;
      endcase
   end
   assign bus.o_ready    = ready;
   assign bus.o_valid    = valid;
   assign bus.o_recip    = recip;
   assign bus.o_sat      = sat;
   assign bus.o_div_zero = dz;
endmodule
